// File: rtl/tree_fanout_pipe.sv
// tree_fanout_pipe: depth-stage valid/ready register pipeline whose last stage
// holds fan separately registered copies of each word, presented side by side
// on dn_dat (copy 0 in the most significant in_w bits).
//
// Parameters:
//   in_w   width of one data word
//   fan    number of output copies (1..8)
//   depth  number of register stages (1..4)
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset; clears valids and all data
//   up_vld   upstream word valid
//   up_dat   upstream word
//   up_rdy   stage 0 ready (combinational through the ready chain)
//   dn_vld   replicated word valid (last stage valid bit)
//   dn_rdy   downstream accepts this cycle
//   dn_dat   fan copies of the last-stage word
//   dn_beats 32-bit count of dn_vld&&dn_rdy cycles, wraps; present only when
//            TREE_FANOUT_BEAT_CNT_EN is defined
module tree_fanout_pipe #(
    parameter int unsigned in_w  = 1024,
    parameter int unsigned fan   = 2,
    parameter int unsigned depth = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                up_vld,
    input  logic [in_w-1:0]     up_dat,
    output logic                up_rdy,
    output logic                dn_vld,
    input  logic                dn_rdy,
    output logic [fan*in_w-1:0] dn_dat
`ifdef TREE_FANOUT_BEAT_CNT_EN
    ,
    output logic [31:0]         dn_beats
`endif
);

    localparam int unsigned LAST = depth - 1;

    logic [depth-1:0]           r_vld;
    logic [depth-1:0]           w_rdy;
    logic [depth-1:0]           w_src_vld;
    logic [depth-1:0][in_w-1:0] w_src_dat;
    logic [fan-1:0][in_w-1:0]   r_copy;

    // Stage k is ready if any stage from k to the end is empty, or downstream
    // takes a word; written without a bit-to-bit chain so the vector has no
    // self-dependence.
    always_comb begin
        w_rdy = '0;
        for (int unsigned k = 0; k < depth; k++) begin
            w_rdy[k] = dn_rdy;
            for (int unsigned j = k; j < depth; j++) begin
                if (!r_vld[j]) begin
                    w_rdy[k] = 1'b1;
                end
            end
        end
    end

    // Source valid of each stage: upstream for stage 0, previous stage otherwise.
    always_comb begin
        w_src_vld    = '0;
        w_src_vld[0] = up_vld;
        for (int unsigned k = 1; k < depth; k++) begin
            w_src_vld[k] = r_vld[k-1];
        end
    end

    assign w_src_dat[0] = up_dat;

    // Valid bits: a ready stage takes its source valid (loads or empties),
    // a stalled stage holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else begin
            for (int unsigned k = 0; k < depth; k++) begin
                if (w_rdy[k]) begin
                    r_vld[k] <= w_src_vld[k];
                end
            end
        end
    end

    // Intermediate data stages (all but the last).
    for (genvar gk = 0; gk < int'(LAST); gk++) begin : g_mid
        logic [in_w-1:0] r_dat;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_dat <= '0;
            end else if (w_rdy[gk] && w_src_vld[gk]) begin
                r_dat <= w_src_dat[gk];
            end
        end

        assign w_src_dat[gk+1] = r_dat;
    end

    // Last stage: fan independent copies sharing one load enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_copy <= '0;
        end else if (w_rdy[LAST] && w_src_vld[LAST]) begin
            for (int unsigned c = 0; c < fan; c++) begin
                r_copy[c] <= w_src_dat[LAST];
            end
        end
    end

    // Copy 0 lands in the top in_w bits.
    for (genvar gc = 0; gc < int'(fan); gc++) begin : g_out
        assign dn_dat[(int'(fan) - 1 - gc)*int'(in_w) +: int'(in_w)] = r_copy[gc];
    end

    assign up_rdy = w_rdy[0];
    assign dn_vld = r_vld[LAST];

`ifdef TREE_FANOUT_BEAT_CNT_EN
    logic [31:0] r_beats;

    // Counts downstream handshakes; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beats <= '0;
        end else if (r_vld[LAST] && dn_rdy) begin
            r_beats <= r_beats + 32'd1;
        end
    end

    assign dn_beats = r_beats;
`endif

endmodule

// File: tb/tb_tree_fanout_pipe.sv
// Directed bench for tree_fanout_pipe: three instances cover
// (in_w=8,fan=2,depth=2), (in_w=8,fan=4,depth=3) and (in_w=8,fan=1,depth=1).
module tb_tree_fanout_pipe;

    logic clk;
    logic rst_n;

    logic        a_up_vld, a_up_rdy, a_dn_vld, a_dn_rdy;
    logic [7:0]  a_up_dat;
    logic [15:0] a_dn_dat;
    logic        b_up_vld, b_up_rdy, b_dn_vld, b_dn_rdy;
    logic [7:0]  b_up_dat;
    logic [31:0] b_dn_dat;
    logic        c_up_vld, c_up_rdy, c_dn_vld, c_dn_rdy;
    logic [7:0]  c_up_dat;
    logic [7:0]  c_dn_dat;
`ifdef TREE_FANOUT_BEAT_CNT_EN
    logic [31:0] a_beats, b_beats, c_beats;
`endif

    int n_total;
    int n_bad;

    tree_fanout_pipe #(.in_w(8), .fan(2), .depth(2)) u_a (
        .clk(clk), .rst_n(rst_n),
        .up_vld(a_up_vld), .up_dat(a_up_dat), .up_rdy(a_up_rdy),
        .dn_vld(a_dn_vld), .dn_rdy(a_dn_rdy), .dn_dat(a_dn_dat)
`ifdef TREE_FANOUT_BEAT_CNT_EN
        , .dn_beats(a_beats)
`endif
    );

    tree_fanout_pipe #(.in_w(8), .fan(4), .depth(3)) u_b (
        .clk(clk), .rst_n(rst_n),
        .up_vld(b_up_vld), .up_dat(b_up_dat), .up_rdy(b_up_rdy),
        .dn_vld(b_dn_vld), .dn_rdy(b_dn_rdy), .dn_dat(b_dn_dat)
`ifdef TREE_FANOUT_BEAT_CNT_EN
        , .dn_beats(b_beats)
`endif
    );

    tree_fanout_pipe #(.in_w(8), .fan(1), .depth(1)) u_c (
        .clk(clk), .rst_n(rst_n),
        .up_vld(c_up_vld), .up_dat(c_up_dat), .up_rdy(c_up_rdy),
        .dn_vld(c_dn_vld), .dn_rdy(c_dn_rdy), .dn_dat(c_dn_dat)
`ifdef TREE_FANOUT_BEAT_CNT_EN
        , .dn_beats(c_beats)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

`ifdef TREE_FANOUT_BEAT_CNT_EN
    task automatic send_a(input logic [7:0] d);
        a_up_vld = 1'b1;
        a_up_dat = d;
        tick();
        a_up_vld = 1'b0;
        tick();
        tick();
    endtask
`endif

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp_w;
        logic [7:0] c_next, m_dat;
        logic       m_vld;
        int         sent, rcvd, cyc, acc, got;

        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        a_up_vld = 1'b0; a_up_dat = '0; a_dn_rdy = 1'b1;
        b_up_vld = 1'b0; b_up_dat = '0; b_dn_rdy = 1'b1;
        c_up_vld = 1'b0; c_up_dat = '0; c_dn_rdy = 1'b1;

        // Reset state, before any clock edge and during reset.
        #1;
        check("rst_a_vld", a_dn_vld, 0);
        check("rst_a_dat", a_dn_dat, 0);
        check("rst_a_rdy", a_up_rdy, 1);
        check("rst_b_dat", b_dn_dat, 0);
        check("rst_b_rdy", b_up_rdy, 1);
        check("rst_c_vld", c_dn_vld, 0);
        check("rst_c_dat", c_dn_dat, 0);
`ifdef TREE_FANOUT_BEAT_CNT_EN
        check("rst_beats", a_beats, 0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back 0x11,0x22,0x33 through fan=2 depth=2.
        a_up_vld = 1'b1; a_up_dat = 8'h11;
        tick();
        check("bb_vld0", a_dn_vld, 0);
        a_up_dat = 8'h22;
        tick();
        check("bb_vld1", a_dn_vld, 1);
        check("bb_dat1", a_dn_dat, 16'h1111);
        a_up_dat = 8'h33;
        tick();
        check("bb_vld2", a_dn_vld, 1);
        check("bb_dat2", a_dn_dat, 16'h2222);
        a_up_vld = 1'b0;
        tick();
        check("bb_vld3", a_dn_vld, 1);
        check("bb_dat3", a_dn_dat, 16'h3333);
        tick();
        check("bb_vld4", a_dn_vld, 0);

        // Fill fan=4 depth=3 with A1..A3 under back-pressure, then drain.
        b_dn_rdy = 1'b0;
        b_up_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_up_dat = 8'hA1 + 8'(i);
            #1;
            check("fill_rdy", b_up_rdy, 1);
            tick();
        end
        b_up_dat = 8'hA4;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_rdy", b_up_rdy, 0);
            check("stall_vld", b_dn_vld, 1);
            check("stall_dat", b_dn_dat, 32'hA1A1A1A1);
            tick();
        end
        b_up_vld = 1'b0;
        b_dn_rdy = 1'b1;
        check("drain_1", b_dn_dat, 32'hA1A1A1A1);
        tick();
        check("drain_v2", b_dn_vld, 1);
        check("drain_2", b_dn_dat, 32'hA2A2A2A2);
        tick();
        check("drain_v3", b_dn_vld, 1);
        check("drain_3", b_dn_dat, 32'hA3A3A3A3);
        tick();
        check("drain_end", b_dn_vld, 0);

        // depth=1 fan=1 with continuous up_vld and dn_rdy toggling.
        c_next = 8'h40;
        m_vld  = 1'b0;
        m_dat  = '0;
        acc    = 0;
        got    = 0;
        for (int i = 0; i < 20; i++) begin
            c_up_vld = 1'b1;
            c_up_dat = c_next;
            c_dn_rdy = i[0];
            #1;
            check("tog_rdy", c_up_rdy, !m_vld || c_dn_rdy);
            check("tog_vld", c_dn_vld, m_vld);
            if (m_vld) check("tog_dat", c_dn_dat, m_dat);
            if (m_vld && c_dn_rdy) got++;
            if (!m_vld || c_dn_rdy) begin
                m_vld = 1'b1;
                m_dat = c_next;
                c_next++;
                acc++;
            end
            tick();
        end
        check("tog_acc", acc, 11);
        check("tog_out", got, 10);
        c_up_vld = 1'b0;
        c_dn_rdy = 1'b1;

        // Reset with two words in flight.
        a_dn_rdy = 1'b1;
        a_up_vld = 1'b1; a_up_dat = 8'h77;
        tick();
        a_up_dat = 8'h88;
        tick();
        a_up_vld = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mrst_vld", a_dn_vld, 0);
        check("mrst_dat", a_dn_dat, 0);
        check("mrst_rdy", a_up_rdy, 1);
        tick();
        rst_n = 1'b1;
        a_up_vld = 1'b1; a_up_dat = 8'h5A;
        tick();
        check("mrst_old", a_dn_vld, 0);
        a_up_vld = 1'b0;
        tick();
        check("mrst_nvld", a_dn_vld, 1);
        check("mrst_ndat", a_dn_dat, 16'h5A5A);
        tick();
        check("mrst_end", a_dn_vld, 0);

        // 1000 incrementing words with random up_vld/dn_rdy, in-order scoreboard.
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        while (rcvd < 1000 && cyc < 20000) begin
            a_up_vld = (sent < 1000) && ($urandom_range(0, 1) == 1);
            a_up_dat = 8'(sent);
            a_dn_rdy = ($urandom_range(0, 1) == 1);
            #1;
            if (a_dn_vld && a_dn_rdy) begin
                if (q.size() == 0) begin
                    check("rnd_extra", 1, 0);
                end else begin
                    exp_w = q.pop_front();
                    check("rnd_lane0", a_dn_dat[15:8], exp_w);
                    check("rnd_lane1", a_dn_dat[7:0], exp_w);
                end
                rcvd++;
            end
            if (a_up_vld && a_up_rdy) begin
                q.push_back(a_up_dat);
                sent++;
            end
            tick();
            cyc++;
        end
        check("rnd_count", rcvd, 1000);
        check("rnd_left", q.size(), 0);
        a_up_vld = 1'b0;
        a_dn_rdy = 1'b1;
        tick();
        tick();
        tick();

`ifdef TREE_FANOUT_BEAT_CNT_EN
        // Beat counter wrap, starting from a forced preload.
        force u_a.r_beats = 32'hFFFF_FFFC;
        #1;
        release u_a.r_beats;
        send_a(8'h01);
        send_a(8'h02);
        check("beat_fe", a_beats, 32'hFFFF_FFFE);
        send_a(8'h03);
        check("beat_ff", a_beats, 32'hFFFF_FFFF);
        send_a(8'h04);
        check("beat_00", a_beats, 32'h0000_0000);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
